// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the ID/EX bundle.
// Imported by the decode and issue stages.
package rv_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_XOR   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_BEQ   = 4'h7;
    localparam logic [3:0] ALU_BNE   = 4'h8;
    localparam logic [3:0] ALU_SLT   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_AUIPC = 4'hB;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           ctrl;
        logic [RV_XLEN-1:0]   in1;
        logic [RV_XLEN-1:0]   in2;
        logic [RV_XLEN-1:0]   pc;
        logic [RV_XLEN-1:0]   br_target;
        logic [RV_XLEN-1:0]   store_data;
        logic [4:0]           rd;
        logic                 reg_we;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 illegal;
    } id_ex_t;

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: instruction and register data
// to ALU control, operands and memory/writeback flags.
module rv_decode
    import rv_pkg::*;
#(
    parameter bit SIGNED_SLT = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output id_ex_t      dec
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        is_r;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [4:0]  shamt;
    logic        f7_zero;
    logic        f7_alt;

    assign op      = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign rd      = instr[11:7];
    assign is_r    = (op == OP_R);
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
    assign shamt   = is_r ? rs2_data[4:0] : instr[24:20];
    assign f7_zero = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);

    logic        ill;
    logic        wr_rd;
    logic [3:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;

    always_comb begin
        ill   = 1'b0;
        wr_rd = 1'b0;
        ctrl  = ALU_ADD;
        in1   = rs1_data;
        in2   = is_r ? rs2_data : imm_i;
        dec   = '0;
        unique case (1'b1)
            (op == OP_R), (op == OP_I): begin
                wr_rd = 1'b1;
                // R-form only allows funct7 0x20 on SUB and SRA
                if (is_r && !f7_zero && !(f7_alt && (f3 == F3_ADD || f3 == F3_SR)))
                    ill = 1'b1;
                case (f3)
                    F3_ADD:  ctrl = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
                    F3_XOR:  ctrl = ALU_XOR;
                    F3_OR:   ctrl = ALU_OR;
                    F3_AND:  ctrl = ALU_AND;
                    F3_SLL: begin
                        ctrl = ALU_SLL;
                        in2  = {27'b0, shamt};
                        if (!f7_zero) ill = 1'b1;
                    end
                    F3_SR: begin
                        ctrl = f7_alt ? ALU_SRA : ALU_SRL;
                        in2  = {27'b0, shamt};
                        if (!f7_zero && !f7_alt) ill = 1'b1;
                    end
                    F3_SLT: begin
                        ctrl = ALU_SLT;
                        if (SIGNED_SLT) begin
                            in1 = in1 ^ 32'h8000_0000;
                            in2 = in2 ^ 32'h8000_0000;
                        end
                    end
                    default: ctrl = ALU_SLT;
                endcase
            end
            (op == OP_LUI): begin
                wr_rd = 1'b1;
                in1   = '0;
                in2   = {instr[31:12], 12'b0};
            end
            (op == OP_AUIPC): begin
                wr_rd = 1'b1;
                ctrl  = ALU_AUIPC;
                in1   = '0;
                in2   = {12'b0, instr[31:12]};
            end
            (op == OP_LOAD): begin
                wr_rd      = 1'b1;
                dec.mem_rd = 1'b1;
                in2        = imm_i;
                if (f3 != F3_W) ill = 1'b1;
            end
            (op == OP_STORE): begin
                dec.mem_wr     = 1'b1;
                dec.store_data = rs2_data;
                in2            = imm_s;
                if (f3 != F3_W) ill = 1'b1;
            end
            (op == OP_BRANCH): begin
                in2           = rs2_data;
                dec.br_target = pc + imm_b;
                case (f3)
                    F3_BEQ:  ctrl = ALU_BEQ;
                    F3_BNE:  ctrl = ALU_BNE;
                    default: ill  = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        dec.valid = 1'b1;
        dec.pc    = pc;
        dec.ctrl  = ctrl;
        dec.in1   = in1;
        dec.in2   = in2;
        dec.rd    = wr_rd ? rd : 5'd0;
        dec.reg_we = wr_rd && (rd != 5'd0);
        if (ill) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.pc      = pc;
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// Issue stage: load-use hazard detection, stall/flush priority
// and the ID/EX pipeline register.
module id_ex_issue
    import rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit SIGNED_SLT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_hold,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [3:0]      ex_ctrl,
    output logic [XLEN-1:0] ex_in1,
    output logic [XLEN-1:0] ex_in2,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_br_target,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_illegal
);

    id_ex_t dec;
    id_ex_t q;
    id_ex_t bub;

    rv_decode #(.SIGNED_SLT(SIGNED_SLT)) u_dec (
        .instr    (id_instr),
        .pc       (id_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       hazard;

    assign op       = id_instr[6:0];
    assign rs1      = id_instr[19:15];
    assign rs2      = id_instr[24:20];
    assign uses_rs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);

    assign hazard = q.valid && q.mem_rd && (q.rd != 5'd0) && id_valid &&
                    ((rs1 == q.rd) || (uses_rs2 && (rs2 == q.rd)));

    assign id_stall = (hazard || ex_hold) && !flush;

    // A bubble keeps the last PC so EX still sees a sane address
    always_comb begin
        bub    = '0;
        bub.pc = q.pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= bub;
        else if (ex_hold)
            q <= q;
        else if (hazard || !id_valid)
            q <= bub;
        else
            q <= dec;
    end

    assign ex_valid      = q.valid;
    assign ex_ctrl       = q.ctrl;
    assign ex_in1        = q.in1;
    assign ex_in2        = q.in2;
    assign ex_pc         = q.pc;
    assign ex_br_target  = q.br_target;
    assign ex_store_data = q.store_data;
    assign ex_rd         = q.rd;
    assign ex_reg_we     = q.reg_we;
    assign ex_mem_rd     = q.mem_rd;
    assign ex_mem_wr     = q.mem_wr;
    assign ex_illegal    = q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed-vector bench for the ID/EX issue stage.
// Expected values are hand-derived from the instruction encodings.
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        ex_hold = 1'b0;
    logic        flush = 1'b0;
    logic        id_stall;
    logic        ex_valid;
    logic [3:0]  ex_ctrl;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [31:0] ex_pc;
    logic [31:0] ex_br_target;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_illegal;

    int n_chk = 0;
    int n_bad = 0;

    id_ex_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_ctrl       (ex_ctrl),
        .ex_in1        (ex_in1),
        .ex_in2        (ex_in2),
        .ex_pc         (ex_pc),
        .ex_br_target  (ex_br_target),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_we     (ex_reg_we),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1;
        id_instr = ins;
        id_pc    = pc;
        rs1_data = a;
        rs2_data = b;
    endtask

    logic [31:0] h_in1;
    logic [31:0] h_in2;

    initial begin
        step();
        step();
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_stall", {31'b0, id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7);
        step();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_ctrl", {28'b0, ex_ctrl}, 32'h0);
        chk("add_in1", ex_in1, 32'd5);
        chk("add_in2", ex_in2, 32'd7);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_we", {31'b0, ex_reg_we}, 32'd1);
        chk("add_ill", {31'b0, ex_illegal}, 32'd0);

        issue(32'h4040D193, 32'h0000_0014, 32'hF000_0000, 32'd0);
        step();
        chk("srai_ctrl", {28'b0, ex_ctrl}, 32'hA);
        chk("srai_in1", ex_in1, 32'hF000_0000);
        chk("srai_in2", ex_in2, 32'd4);

        issue(32'h0020A1B3, 32'h0000_0018, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("slt_ctrl", {28'b0, ex_ctrl}, 32'h9);
        chk("slt_in1", ex_in1, 32'h7FFF_FFFF);
        chk("slt_in2", ex_in2, 32'h8000_0001);

        issue(32'h12345217, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0);
        step();
        chk("auipc_ctrl", {28'b0, ex_ctrl}, 32'hB);
        chk("auipc_in1", ex_in1, 32'd0);
        chk("auipc_in2", ex_in2, 32'h0001_2345);
        chk("auipc_pc", ex_pc, 32'h0000_0100);
        chk("auipc_rd", {27'b0, ex_rd}, 32'd4);

        issue(32'h00208463, 32'h0000_0200, 32'd9, 32'd9);
        step();
        chk("beq_ctrl", {28'b0, ex_ctrl}, 32'h7);
        chk("beq_tgt", ex_br_target, 32'h0000_0208);
        chk("beq_we", {31'b0, ex_reg_we}, 32'd0);
        chk("beq_in2", ex_in2, 32'd9);

        issue(32'h0000A283, 32'h0000_0300, 32'h0000_1000, 32'd0);
        step();
        chk("lw_mrd", {31'b0, ex_mem_rd}, 32'd1);
        chk("lw_rd", {27'b0, ex_rd}, 32'd5);
        chk("lw_in1", ex_in1, 32'h0000_1000);
        issue(32'h00228333, 32'h0000_0304, 32'd11, 32'd22);
        #1;
        chk("lu_stall", {31'b0, id_stall}, 32'd1);
        step();
        chk("lu_bub_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bub_mrd", {31'b0, ex_mem_rd}, 32'd0);
        chk("lu_bub_pc", ex_pc, 32'h0000_0300);
        chk("lu_stall_off", {31'b0, id_stall}, 32'd0);
        step();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, ex_rd}, 32'd6);
        chk("lu_add_in1", ex_in1, 32'd11);
        chk("lu_add_in2", ex_in2, 32'd22);

        issue(32'h002081B3, 32'h0000_0400, 32'd1, 32'd2);
        ex_hold = 1'b1;
        flush   = 1'b1;
        #1;
        chk("fh_stall", {31'b0, id_stall}, 32'd0);
        step();
        chk("fh_valid", {31'b0, ex_valid}, 32'd0);
        chk("fh_stall2", {31'b0, id_stall}, 32'd0);
        ex_hold = 1'b0;
        flush   = 1'b0;

        issue(32'h002081B3, 32'h0000_0500, 32'd100, 32'd200);
        step();
        h_in1 = ex_in1;
        h_in2 = ex_in2;
        chk("hold_pre", h_in1, 32'd100);
        ex_hold = 1'b1;
        issue(32'h4040D193, 32'h0000_0504, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_in1", ex_in1, 32'd100);
            chk("hold_in2", ex_in2, 32'd200);
            chk("hold_pc", ex_pc, 32'h0000_0500);
            chk("hold_stall", {31'b0, id_stall}, 32'd1);
        end
        ex_hold = 1'b0;

        id_valid = 1'b0;
        step();
        chk("idle_valid", {31'b0, ex_valid}, 32'd0);
        chk("idle_pc", ex_pc, 32'h0000_0500);

        issue(32'h002081B3, 32'h0000_0600, 32'd1, 32'd2);
        step();
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_in1", ex_in1, 32'd0);
        chk("arst_we", {31'b0, ex_reg_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h008000EF, 32'h0000_0700, 32'd1, 32'd2);
        step();
        chk("jal_valid", {31'b0, ex_valid}, 32'd1);
        chk("jal_ill", {31'b0, ex_illegal}, 32'd1);
        chk("jal_we", {31'b0, ex_reg_we}, 32'd0);
        chk("jal_ctrl", {28'b0, ex_ctrl}, 32'h0);

        id_valid = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
